// File: rtl/cpu_reg_access.sv
// CPU-side register-access front end for the vicii core: re-times the async 6510 bus
// into clk_dot4x, qualifies accesses against phi high and issues register-file strobes.
module cpu_reg_access #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_REGS      = 47
) (
    input  logic       clk_dot4x,
    input  logic       rst_n,
    input  logic       clk_phi,
    input  logic       ce,
    input  logic       rw,
    input  logic [5:0] adi,
    input  logic [7:0] dbi,
    input  logic [7:0] rdata,
    output logic       reg_re,
    output logic       reg_we,
    output logic [5:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic [7:0] dbo,
    output logic       db_oe,
    output logic       busy
);

    localparam logic [6:0] NUM_REGS_7  = 7'(NUM_REGS);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RDREQ,
        RDCAP,
        READ,
        WRWAIT,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       phi_q;
    logic       phi_rise;
    logic       phi_fall;

    logic       ce_sync  [SYNC_STAGES];
    logic       rw_sync  [SYNC_STAGES];
    logic [5:0] adi_sync [SYNC_STAGES];
    logic [7:0] dbi_sync [SYNC_STAGES];

    logic       ce_s;
    logic       rw_s;
    logic [5:0] adi_s;
    logic [7:0] dbi_s;

    function automatic logic is_mapped(input logic [5:0] addr);
        return {1'b0, addr} < NUM_REGS_7;
    endfunction

    // Pin synchronisers, preset to a deselected, idle bus
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ce_sync[i]  <= 1'b1;
                rw_sync[i]  <= 1'b1;
                adi_sync[i] <= 6'h00;
                dbi_sync[i] <= 8'h00;
            end
            phi_q <= 1'b0;
        end else begin
            ce_sync[0]  <= ce;
            rw_sync[0]  <= rw;
            adi_sync[0] <= adi;
            dbi_sync[0] <= dbi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ce_sync[i]  <= ce_sync[i-1];
                rw_sync[i]  <= rw_sync[i-1];
                adi_sync[i] <= adi_sync[i-1];
                dbi_sync[i] <= dbi_sync[i-1];
            end
            phi_q <= clk_phi;
        end
    end

    assign ce_s     = ce_sync[SYNC_STAGES-1];
    assign rw_s     = rw_sync[SYNC_STAGES-1];
    assign adi_s    = adi_sync[SYNC_STAGES-1];
    assign dbi_s    = dbi_sync[SYNC_STAGES-1];
    assign phi_rise = clk_phi & ~phi_q;
    assign phi_fall = ~clk_phi & phi_q;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            reg_re    <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= 6'h00;
            reg_wdata <= 8'h00;
            dbo       <= 8'h00;
            db_oe     <= 1'b0;
        end else begin
            reg_re <= 1'b0;
            reg_we <= 1'b0;
            db_oe  <= 1'b0;
            case (state)
                IDLE: begin
                    if (phi_rise) begin
                        state <= SETTLE;
                        cnt   <= 4'd0;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                    // A phi fall always aborts, so a too-short phi-high never starts an access
                    if (phi_fall) begin
                        state <= IDLE;
                    end else if (cnt == SETTLE_LAST) begin
                        if (ce_s) begin
                            state <= DONE;
                        end else begin
                            reg_addr <= adi_s;
                            if (!rw_s) begin
                                state <= WRWAIT;
                            end else if (is_mapped(adi_s)) begin
                                reg_re <= 1'b1;
                                state  <= RDREQ;
                            end else begin
                                dbo   <= 8'hFF;
                                state <= READ;
                            end
                        end
                    end
                end
                RDREQ: state <= RDCAP;
                RDCAP: begin
                    dbo   <= rdata;
                    state <= READ;
                end
                READ: begin
                    if (phi_fall || ce_s) begin
                        state <= IDLE;
                    end else begin
                        db_oe <= 1'b1;
                    end
                end
                WRWAIT: begin
                    // The sync lag means dbi_s at the fall still carries the pre-fall bus value
                    reg_wdata <= dbi_s;
                    if (phi_fall) begin
                        reg_we <= is_mapped(reg_addr);
                        state  <= IDLE;
                    end else if (ce_s) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (phi_fall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_reg_access.sv
// Scoreboard bench for cpu_reg_access: bus accesses push expected strobe/output events,
// a monitor pops and compares them as the DUT produces them.
module tb_cpu_reg_access;

    localparam int SETTLE_CYCLES = 4;

    localparam logic [3:0] K_BUSY_ON  = 4'd0;
    localparam logic [3:0] K_RE       = 4'd1;
    localparam logic [3:0] K_WE       = 4'd2;
    localparam logic [3:0] K_OE_ON    = 4'd3;
    localparam logic [3:0] K_OE_OFF   = 4'd4;
    localparam logic [3:0] K_BUSY_OFF = 4'd5;

    typedef struct {
        logic [3:0] kind;
        logic [5:0] addr;
        logic [7:0] data;
        int         lat;
    } ev_t;

    logic       clk_dot4x;
    logic       rst_n;
    logic       clk_phi;
    logic       ce;
    logic       rw;
    logic [5:0] adi;
    logic [7:0] dbi;
    logic [7:0] rdata;
    logic       reg_re;
    logic       reg_we;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] dbo;
    logic       db_oe;
    logic       busy;

    logic [7:0] mem [64];
    ev_t        exp_q [$];
    int         n_cmp;
    int         n_bad;
    int         n_ev;
    int         cyc;
    int         rise_cyc;
    int         fall_cyc;
    logic       mon_en;
    logic       track_busy;
    logic       prev_phi;
    logic       prev_oe;
    logic       prev_busy;

    cpu_reg_access #(
        .SYNC_STAGES  (2),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .NUM_REGS     (47)
    ) dut (
        .clk_dot4x(clk_dot4x),
        .rst_n    (rst_n),
        .clk_phi  (clk_phi),
        .ce       (ce),
        .rw       (rw),
        .adi      (adi),
        .dbi      (dbi),
        .rdata    (rdata),
        .reg_re   (reg_re),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .dbo      (dbo),
        .db_oe    (db_oe),
        .busy     (busy)
    );

    initial clk_dot4x = 1'b0;
    always #5 clk_dot4x = ~clk_dot4x;

    // Register-file model: data appears one cycle after the read strobe
    always @(posedge clk_dot4x) begin
        if (reg_re) rdata <= mem[reg_addr];
        else        rdata <= 8'h00;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic [3:0] k, input logic [5:0] a, input logic [7:0] d, input int lat);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    task automatic emit(input logic [3:0] k, input logic [5:0] a, input logic [7:0] d, input int lat);
        ev_t e;
        n_ev++;
        if (exp_q.size() == 0) begin
            check_val($sformatf("ev%0d_spurious_kind", n_ev), 32'(k), 32'hFF);
        end else begin
            e = exp_q.pop_front();
            check_val($sformatf("ev%0d_kind", n_ev), 32'(k), 32'(e.kind));
            check_val($sformatf("ev%0d_addr", n_ev), 32'(a), 32'(e.addr));
            check_val($sformatf("ev%0d_data", n_ev), 32'(d), 32'(e.data));
            check_val($sformatf("ev%0d_lat", n_ev), 32'(lat), 32'(e.lat));
        end
    endtask

    // Monitor samples 1 ns after each active edge; latencies count edges from the
    // edge at which the phi rise/fall is first registered
    always @(posedge clk_dot4x) begin
        #1;
        cyc++;
        if (clk_phi && !prev_phi) rise_cyc = cyc;
        if (!clk_phi && prev_phi) fall_cyc = cyc;
        if (mon_en) begin
            if (track_busy && busy && !prev_busy) emit(K_BUSY_ON, 6'h00, 8'h00, cyc - rise_cyc);
            if (reg_re)                           emit(K_RE, reg_addr, 8'h00, cyc - rise_cyc);
            if (reg_we)                           emit(K_WE, reg_addr, reg_wdata, cyc - fall_cyc);
            if (db_oe && !prev_oe)                emit(K_OE_ON, reg_addr, dbo, cyc - rise_cyc);
            if (!db_oe && prev_oe)                emit(K_OE_OFF, reg_addr, dbo, cyc - fall_cyc);
            if (track_busy && !busy && prev_busy) emit(K_BUSY_OFF, 6'h00, 8'h00, cyc - fall_cyc);
        end
        prev_phi  = clk_phi;
        prev_oe   = db_oe;
        prev_busy = busy;
    end

    // One phi period driven from negedges; an optional mid-high event changes dbi/ce
    task automatic phi_cyc(input int hi, input int lo, input int ev_at,
                           input logic [7:0] ev_dbi, input logic ev_ce);
        clk_phi = 1'b1;
        for (int k = 0; k < hi; k++) begin
            @(negedge clk_dot4x);
            if (k == ev_at) begin
                dbi = ev_dbi;
                ce  = ev_ce;
            end
        end
        clk_phi = 1'b0;
        repeat (lo) @(negedge clk_dot4x);
    endtask

    task automatic set_bus(input logic c, input logic r, input logic [5:0] a, input logic [7:0] d);
        ce  = c;
        rw  = r;
        adi = a;
        dbi = d;
    endtask

    task automatic expect_read(input logic [5:0] a, input logic [7:0] d);
        push_ev(K_RE, a, 8'h00, SETTLE_CYCLES);
        push_ev(K_OE_ON, a, d, SETTLE_CYCLES + 3);
        push_ev(K_OE_OFF, a, d, 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_ev = 0; cyc = 0; rise_cyc = 0; fall_cyc = 0;
        mon_en = 1'b0; track_busy = 1'b0;
        prev_phi = 1'b0; prev_oe = 1'b0; prev_busy = 1'b0;
        rdata = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
        mem[6'h20] = 8'h0E;
        mem[6'h00] = 8'h3C;
        mem[6'h05] = 8'h77;
        rst_n = 1'b0;
        clk_phi = 1'b0;
        set_bus(1'b1, 1'b1, 6'h00, 8'h00);

        repeat (3) @(negedge clk_dot4x);
        check_val("rst_reg_re", 32'(reg_re), 32'h0);
        check_val("rst_reg_we", 32'(reg_we), 32'h0);
        check_val("rst_reg_addr", 32'(reg_addr), 32'h0);
        check_val("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        check_val("rst_dbo", 32'(dbo), 32'h0);
        check_val("rst_db_oe", 32'(db_oe), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk_dot4x);
        mon_en = 1'b1;

        // Mapped read
        set_bus(1'b0, 1'b1, 6'h20, 8'h00);
        expect_read(6'h20, 8'h0E);
        phi_cyc(16, 16, -1, 8'h00, 1'b0);

        // Mapped write, data changes mid-phi
        set_bus(1'b0, 1'b0, 6'h11, 8'h00);
        push_ev(K_WE, 6'h11, 8'hA5, 0);
        phi_cyc(16, 16, 8, 8'hA5, 1'b0);
        check_val("wdata_hold", 32'(reg_wdata), 32'hA5);

        // Unmapped read then unmapped write
        set_bus(1'b0, 1'b1, 6'h3A, 8'h00);
        push_ev(K_OE_ON, 6'h3A, 8'hFF, SETTLE_CYCLES + 1);
        push_ev(K_OE_OFF, 6'h3A, 8'hFF, 0);
        phi_cyc(16, 16, -1, 8'h00, 1'b0);
        set_bus(1'b0, 1'b0, 6'h3A, 8'h5A);
        phi_cyc(16, 16, -1, 8'h00, 1'b0);

        // Deselected for three phi periods: busy pulses only
        set_bus(1'b1, 1'b1, 6'h01, 8'h00);
        track_busy = 1'b1;
        for (int p = 0; p < 3; p++) begin
            push_ev(K_BUSY_ON, 6'h00, 8'h00, 0);
            push_ev(K_BUSY_OFF, 6'h00, 8'h00, 0);
            phi_cyc(16, 16, -1, 8'h00, 1'b1);
        end
        track_busy = 1'b0;

        // Async reset in the middle of a read
        mon_en = 1'b0;
        set_bus(1'b0, 1'b1, 6'h20, 8'h00);
        clk_phi = 1'b1;
        repeat (10) @(negedge clk_dot4x);
        check_val("oe_before_rst", 32'(db_oe), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_mid_db_oe", 32'(db_oe), 32'h0);
        check_val("rst_mid_busy", 32'(busy), 32'h0);
        check_val("rst_mid_dbo", 32'(dbo), 32'h0);
        clk_phi = 1'b0;
        set_bus(1'b1, 1'b1, 6'h00, 8'h00);
        repeat (3) @(negedge clk_dot4x);
        rst_n = 1'b1;
        repeat (6) @(negedge clk_dot4x);
        mon_en = 1'b1;
        set_bus(1'b0, 1'b1, 6'h00, 8'h00);
        expect_read(6'h00, 8'h3C);
        phi_cyc(16, 16, -1, 8'h00, 1'b0);

        // Chip deselected mid-write: no strobe
        set_bus(1'b0, 1'b0, 6'h12, 8'h99);
        phi_cyc(16, 16, 10, 8'h99, 1'b1);

        // Phi high too short to settle: no access, then a normal read recovers
        set_bus(1'b0, 1'b1, 6'h05, 8'h00);
        phi_cyc(2, 16, -1, 8'h00, 1'b0);
        check_val("idle_after_short", 32'(busy), 32'h0);
        expect_read(6'h05, 8'h77);
        phi_cyc(16, 16, -1, 8'h00, 1'b0);

        repeat (4) @(negedge clk_dot4x);
        check_val("pending_evts", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
